seq_alu: RTL

//  Parametrised, registered ALU with valid/ready handshakes on input and output.

---
 rtl/seq_alu.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes, pre-shifted operand B and a
// bit-serial shift-add multiplier; result and NZCV flags held until consumed.
`timescale 1ns/1ps
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       bshift,
   input  logic [2:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       ALUFlags,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [CW-1:0]    cnt_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;

   logic [WIDTH-1:0] bsh_s;
   logic [WIDTH:0]   add_s;
   logic [WIDTH:0]   sub_s;
   logic [WIDTH-1:0] res_d;
   logic             c_d;
   logic             v_d;
   logic [3:0]       flags_d;
   logic [WIDTH-1:0] mul_sum_s;
   logic [3:0]       mul_flags_s;

   assign bsh_s       = b << bshift;
   assign mul_sum_s   = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
   assign mul_flags_s = {mul_sum_s[WIDTH-1], (mul_sum_s == {WIDTH{1'b0}}), 2'b00};

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign Result    = result_q;
   assign ALUFlags  = flags_q;

   // Single-cycle datapath: result and NZCV for the operation presented now
   always_comb begin
      add_s = {1'b0, a} + {1'b0, bsh_s};
      sub_s = {1'b0, a} + {1'b0, ~bsh_s} + {{WIDTH{1'b0}}, 1'b1};
      res_d = {WIDTH{1'b0}};
      c_d   = 1'b0;
      v_d   = 1'b0;
      case (ALUControl)
         3'b000: begin
            res_d = add_s[WIDTH-1:0];
            c_d   = add_s[WIDTH];
            v_d   = (a[WIDTH-1] == bsh_s[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
         end
         3'b001: begin
            res_d = sub_s[WIDTH-1:0];
            c_d   = sub_s[WIDTH];
            v_d   = (a[WIDTH-1] != bsh_s[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
         end
         3'b010: res_d = a & bsh_s;
         3'b011: res_d = a | bsh_s;
         3'b100: res_d = a ^ bsh_s;
         3'b101: begin
            if (bsh_s >= W_LIM) res_d = {WIDTH{1'b0}};
            else                res_d = a << bsh_s;
         end
         3'b110: begin
            if (bsh_s >= W_LIM) res_d = {WIDTH{1'b0}};
            else                res_d = a >> bsh_s;
         end
         default: res_d = {WIDTH{1'b0}};
      endcase
      flags_d = {res_d[WIDTH-1], (res_d == {WIDTH{1'b0}}), c_d, v_d};
   end

   // Control FSM plus multiplier and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         mcand_q     <= {WIDTH{1'b0}};
         mplier_q    <= {WIDTH{1'b0}};
         acc_q       <= {WIDTH{1'b0}};
         cnt_q       <= {CW{1'b0}};
         out_valid_q <= 1'b0;
         result_q    <= {WIDTH{1'b0}};
         flags_q     <= 4'b0000;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  if (ALUControl == 3'b111) begin
                     mcand_q  <= a;
                     mplier_q <= bsh_s;
                     acc_q    <= {WIDTH{1'b0}};
                     cnt_q    <= {CW{1'b0}};
                     state_q  <= S_MUL;
                  end else begin
                     result_q    <= res_d;
                     flags_q     <= flags_d;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               // one multiplier bit per cycle, LSB first
               acc_q    <= mul_sum_s;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_q == CW'(WIDTH - 1)) begin
                  result_q    <= mul_sum_s;
                  flags_q     <= mul_flags_s;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
